quad_step_decoder: RTL and testbench
====================================

Name: quad_step_decoder

Overview:
- Upstream stage of the position up/down counter.
- Conditions raw quadrature encoder channels A/B with a 2-flop synchronizer and a per-channel glitch filter, then decodes the Gray-code transitions.
- Outputs a one-cycle step pulse plus a direction level. dir drives the counter's up/down control; step qualifies its count enable.
- Flags illegal double-edge transitions with a sticky error.

Parameters:
- FILT_CYC, 4: consecutive clock edges a synchronized input must differ from its filtered value before the filtered value updates. Legal range 1..255.
- FILT_W, 8: width of the filter counters. Must satisfy 2^FILT_W > FILT_CYC.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- en  in  1  decode enable
- a_in  in  1  raw encoder channel A, asynchronous to clk
- b_in  in  1  raw encoder channel B, asynchronous to clk
- err_clr  in  1  synchronous clear of err
- step  out  1  one-cycle pulse per legal quadrature transition
- dir  out  1  1 = forward (count up), 0 = reverse; holds last legal direction
- err  out  1  sticky illegal-transition flag
- ab_q  out  2  current filtered {A,B}, for debug

Behaviour:
- Reset (rst=0, asynchronous): sync flops, filter counters, filtered A/B, previous-state register, step, dir and err all go to 0. ab_q=2'b00.
- Synchronizer: two flops per channel. No logic between the stages.
- Glitch filter, per channel and independent:
  - Counter increments on each edge where sync out != filtered.
  - Counter clears on any edge where they match.
  - When the counter would reach FILT_CYC, filtered takes sync out and the counter clears on that same edge.
  - A pulse shorter than FILT_CYC cycles never propagates.
- Decode, registered: compare prev {A,B} against filtered {A,B} every edge. Then prev <= filtered.
  - Forward sequence: 00->01->11->10->00. Gives step=1, dir=1.
  - Reverse sequence: 00->10->11->01->00. Gives step=1, dir=0.
  - No change: step=0, dir holds.
  - Both bits changed: err=1, step=0, dir holds.
- Latency: a change first sampled by sync1 at edge k reaches filtered at edge k+FILT_CYC+1. step is high for exactly one cycle after edge k+FILT_CYC+2; dir is valid in that same cycle.
- en=0:
  - step forced 0; no err setting; dir holds.
  - Sync, filter and prev keep tracking, so no spurious step is produced on re-enable.
  - en is sampled at the decode edge.
- err_clr: clears err on the next edge. If an illegal transition is decoded on the same edge, set wins and err stays 1.
- Consecutive legal transitions produce back-to-back step pulses on successive edges; no gap is inserted. The minimum spacing is bounded by the filter.
- Reset mid-filter: all counters clear, filtered returns to 00, no step is emitted. After release, a held nonzero input is filtered as a normal transition from 00:
  - A=0, B=1 produces one forward step.
  - A=1, B=1 produces err.
- Wrap-around: 10->00 is a forward step and 00->10 is a reverse step, the same as any other legal transition.

Decomposition:
- Shared package quad_pkg holds:
  - localparams for the four Gray states (ST00, ST01, ST11, ST10)
  - a function fwd_next(state) returning the forward successor, used for both direction tests
  - the FILT_CYC default
- One sub-module, quad_glitch_filter: synchronizer, counter and filtered flop for one channel. Instantiated twice (A, B).
- Decode and err logic stay in quad_step_decoder.

Test Plan:
- Reset: hold rst=0 with a_in=b_in=1. Require step=0, dir=0, err=0, ab_q=00. Release rst, FILT_CYC=4: require err=1 after edge k+6, because 00->11 is illegal.
- Forward: en=1, FILT_CYC=4. Drive AB 00->01->11->10->00, each held 10 cycles. Require 4 step pulses, each 1 cycle wide, dir=1. The first pulse arrives 6 edges after the change is sampled.
- Reverse: drive 00->10->11->01->00. Require 4 pulses with dir=0. Then one forward edge 00->01: require one pulse with dir=1.
- Glitch: pulse a_in high for 3 cycles, FILT_CYC=4. Require no step and ab_q unchanged. Repeat with a 4-cycle pulse: require exactly 2 steps, 01-edge forward then back reverse.
- Illegal/err: drive a_in and b_in 0->1 together. Require err=1 and no step. Assert err_clr for 1 cycle: err=0. Repeat with err_clr coincident with the illegal decode edge: require err stays 1.
- Enable: en=0 through a full forward cycle. Require 0 steps and ab_q=00 at the end. Set en=1, then drive 00->01: require exactly 1 step, dir=1.

Source files
------------

// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature step decoder: Gray-state names,
// the forward-successor helper and the default filter length.
package quad_pkg;

  // Default number of consecutive differing samples before a channel flips.
  localparam int FILT_CYC_DEF = 4;

  // Quadrature Gray states, written as {A,B}.
  localparam logic [1:0] ST00 = 2'b00;
  localparam logic [1:0] ST01 = 2'b01;
  localparam logic [1:0] ST11 = 2'b11;
  localparam logic [1:0] ST10 = 2'b10;

  // Forward successor in the cycle 00 -> 01 -> 11 -> 10 -> 00.
  // A reverse step is simply a forward step seen from the other side:
  // fwd_next(new) == old.
  function automatic logic [1:0] fwd_next(input logic [1:0] state);
    logic [1:0] nxt;
    nxt = ST00;
    case (state)
      ST00:    nxt = ST01;
      ST01:    nxt = ST11;
      ST11:    nxt = ST10;
      default: nxt = ST00;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/quad_glitch_filter.sv
// One encoder channel: two-flop synchronizer followed by a persistence
// filter. The filtered value only follows the synchronized input after it
// has disagreed with it for FILT_CYC consecutive clock edges; any edge on
// which they agree restarts the count, so short pulses are swallowed.
// FILT_CYC must be 1..255 and 2**FILT_W must exceed FILT_CYC.
module quad_glitch_filter
  import quad_pkg::*;
#(
  parameter int FILT_CYC = FILT_CYC_DEF,
  parameter int FILT_W   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic filt_out
);

  // Count value on which the next mismatching edge completes the run.
  localparam logic [FILT_W-1:0] CNT_LAST = FILT_W'(FILT_CYC - 1);

  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic [FILT_W-1:0] cnt_q,   cnt_d;
  logic              filt_q,  filt_d;

  // Next-state: plain synchronizer shift plus mismatch run counter.
  always_comb begin
    sync1_d = raw_in;
    sync2_d = sync1_q;
    cnt_d   = cnt_q;
    filt_d  = filt_q;
    if (sync2_q != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = sync2_q;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + FILT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // State registers, asynchronously cleared by the active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      filt_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      filt_q  <= filt_d;
    end
  end

  assign filt_out = filt_q;

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature step decoder: filters raw A/B, then compares the previous
// filtered {A,B} with the current one on every edge.
//
// Interface contract: step is a valid-only strobe with no ready. It is
// high for exactly one cycle per legal transition and dir is valid in that
// same cycle; the downstream counter must take it that cycle. Back-to-back
// strobes on successive cycles are possible. dir holds between strobes.
module quad_step_decoder
  import quad_pkg::*;
#(
  parameter int FILT_CYC = FILT_CYC_DEF,
  parameter int FILT_W   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       a_in,
  input  logic       b_in,
  input  logic       err_clr,
  output logic       step,
  output logic       dir,
  output logic       err,
  output logic [1:0] ab_q
);

  logic       a_filt;
  logic       b_filt;
  logic [1:0] ab_cur;

  logic [1:0] prev_q, prev_d;
  logic       step_q, step_d;
  logic       dir_q,  dir_d;
  logic       err_q,  err_d;

  logic [1:0] changed;
  logic       is_fwd;
  logic       is_rev;

  quad_glitch_filter #(
    .FILT_CYC (FILT_CYC),
    .FILT_W   (FILT_W)
  ) u_filt_a (
    .clk      (clk),
    .rst      (rst),
    .raw_in   (a_in),
    .filt_out (a_filt)
  );

  quad_glitch_filter #(
    .FILT_CYC (FILT_CYC),
    .FILT_W   (FILT_W)
  ) u_filt_b (
    .clk      (clk),
    .rst      (rst),
    .raw_in   (b_in),
    .filt_out (b_filt)
  );

  assign ab_cur = {a_filt, b_filt};

  // Decode prev -> current. prev always tracks, even with en low, so that
  // re-enabling never sees a stale state. Error set wins over err_clr.
  always_comb begin
    prev_d  = ab_cur;
    step_d  = 1'b0;
    dir_d   = dir_q;
    err_d   = err_q;
    changed = ab_cur ^ prev_q;
    is_fwd  = (fwd_next(prev_q) == ab_cur);
    is_rev  = (fwd_next(ab_cur) == prev_q);
    if (err_clr) begin
      err_d = 1'b0;
    end
    if (en) begin
      if (changed == 2'b11) begin
        err_d = 1'b1;
      end else if (is_fwd) begin
        step_d = 1'b1;
        dir_d  = 1'b1;
      end else if (is_rev) begin
        step_d = 1'b1;
        dir_d  = 1'b0;
      end
    end
  end

  // Registered decode outputs and previous-state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q <= ST00;
      step_q <= 1'b0;
      dir_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      prev_q <= prev_d;
      step_q <= step_d;
      dir_q  <= dir_d;
      err_q  <= err_d;
    end
  end

  assign step = step_q;
  assign dir  = dir_q;
  assign err  = err_q;
  assign ab_q = ab_cur;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Bench for quad_step_decoder: directed scenarios followed by a random
// walk, checked against a sample-history reference model and a step
// scoreboard keyed on the expected cycle of each pulse.
module tb_quad_step_decoder;

  localparam int FC = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       en      = 1'b0;
  logic       a_in    = 1'b0;
  logic       b_in    = 1'b0;
  logic       err_clr = 1'b0;
  logic       step;
  logic       dir;
  logic       err;
  logic [1:0] ab_q;

  quad_step_decoder #(
    .FILT_CYC (FC),
    .FILT_W   (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .a_in    (a_in),
    .b_in    (b_in),
    .err_clr (err_clr),
    .step    (step),
    .dir     (dir),
    .err     (err),
    .ab_q    (ab_q)
  );

  // ---------------- bookkeeping ----------------
  int n_checks   = 0;
  int n_errors   = 0;
  int cyc        = 0;
  int steps_seen = 0;

  // Expected steps: {dir, cycle number of the edge after which step is high}
  logic [32:0] exp_q[$];

  task automatic check_val(input string name, input logic [31:0] act,
                           input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Raw samples per edge; the synchronizer makes the filter see the sample
  // taken two edges earlier. A channel flips once the last FC samples it
  // saw all disagree with its filtered value.
  logic       ha[$];
  logic       hb[$];
  logic       m_fa, m_fb;
  logic [1:0] m_prev;
  logic       m_dir, m_err;

  function automatic int gray_pos(input logic [1:0] v);
    case (v)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic model_reset();
    m_fa = 1'b0;
    m_fb = 1'b0;
    m_prev = 2'b00;
    m_dir = 1'b0;
    m_err = 1'b0;
    ha.delete();
    hb.delete();
    for (int i = 0; i < FC + 2; i++) begin
      ha.push_back(1'b0);
      hb.push_back(1'b0);
    end
  endtask

  always @(posedge clk) begin : model
    logic [1:0] old_ab;
    logic [1:0] new_ab;
    bit flip_a;
    bit flip_b;
    cyc++;
    if (!rst) begin
      model_reset();
    end else begin
      ha.push_back(a_in);
      hb.push_back(b_in);
      void'(ha.pop_front());
      void'(hb.pop_front());
      flip_a = 1'b1;
      flip_b = 1'b1;
      for (int j = 0; j < FC; j++) begin
        if (ha[FC - 1 - j] == m_fa) flip_a = 1'b0;
        if (hb[FC - 1 - j] == m_fb) flip_b = 1'b0;
      end
      old_ab = m_prev;
      new_ab = {m_fa, m_fb};
      if (err_clr) m_err = 1'b0;
      if (en && (old_ab != new_ab)) begin
        if ((old_ab ^ new_ab) == 2'b11) begin
          m_err = 1'b1;
        end else begin
          m_dir = (gray_pos(new_ab) == ((gray_pos(old_ab) + 1) % 4));
          exp_q.push_back({m_dir, 32'(cyc)});
        end
      end
      m_prev = new_ab;
      if (flip_a) m_fa = ~m_fa;
      if (flip_b) m_fb = ~m_fb;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clk) begin : monitor
    logic [32:0] e;
    #2;
    check_val("dir_level", dir, m_dir);
    check_val("err_level", err, m_err);
    check_val("ab_q", ab_q, {m_fa, m_fb});
    if (exp_q.size() > 0 && exp_q[0][31:0] == 32'(cyc)) begin
      e = exp_q.pop_front();
      check_val("step_expected", step, 1'b1);
      check_val("step_dir", dir, e[32]);
    end else if (step) begin
      check_val("step_unexpected", step, 1'b0);
    end
    if (step) steps_seen++;
  end

  // ---------------- driver tasks ----------------
  task automatic set_ab(input logic [1:0] v);
    @(negedge clk);
    a_in = v[1];
    b_in = v[0];
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int s0;
  logic [1:0] rv;
  int hold;

  initial begin
    // Reset held with both inputs high.
    rst = 1'b0; en = 1'b1; a_in = 1'b1; b_in = 1'b1;
    wait_cyc(3);
    check_val("rst_step", step, 1'b0);
    check_val("rst_dir", dir, 1'b0);
    check_val("rst_err", err, 1'b0);
    check_val("rst_ab_q", ab_q, 2'b00);
    rst = 1'b1;                         // edge k is the next posedge
    repeat (6) @(posedge clk);          // edge k+5
    #2 check_val("rst_err_early", err, 1'b0);
    @(posedge clk);                     // edge k+6
    #2 check_val("rst_err_k6", err, 1'b1);

    // Clean restart from 00.
    @(negedge clk);
    rst = 1'b0; a_in = 1'b0; b_in = 1'b0;
    wait_cyc(2);
    rst = 1'b1;
    wait_cyc(8);

    // Forward cycle with latency and width check on the first step.
    s0 = steps_seen;
    set_ab(2'b01);
    repeat (6) @(posedge clk);
    #2 check_val("fwd_lat_early", step, 1'b0);
    @(posedge clk);
    #2 check_val("fwd_lat_step", step, 1'b1);
    check_val("fwd_lat_dir", dir, 1'b1);
    @(posedge clk);
    #2 check_val("fwd_width", step, 1'b0);
    wait_cyc(2);
    set_ab(2'b11); wait_cyc(10);
    set_ab(2'b10); wait_cyc(10);
    set_ab(2'b00); wait_cyc(10);
    check_val("fwd_count", steps_seen - s0, 4);
    check_val("fwd_dir", dir, 1'b1);

    // Reverse cycle then one forward edge.
    s0 = steps_seen;
    set_ab(2'b10); wait_cyc(10);
    set_ab(2'b11); wait_cyc(10);
    set_ab(2'b01); wait_cyc(10);
    set_ab(2'b00); wait_cyc(10);
    check_val("rev_count", steps_seen - s0, 4);
    check_val("rev_dir", dir, 1'b0);
    s0 = steps_seen;
    set_ab(2'b01); wait_cyc(10);
    check_val("rev_then_fwd_count", steps_seen - s0, 1);
    check_val("rev_then_fwd_dir", dir, 1'b1);
    set_ab(2'b00); wait_cyc(10);

    // Glitches: 3-cycle pulse is swallowed, 4-cycle pulse passes.
    s0 = steps_seen;
    set_ab(2'b10); wait_cyc(2);
    set_ab(2'b00); wait_cyc(10);
    check_val("glitch3_count", steps_seen - s0, 0);
    check_val("glitch3_ab_q", ab_q, 2'b00);
    s0 = steps_seen;
    set_ab(2'b01); wait_cyc(3);
    set_ab(2'b00); wait_cyc(15);
    check_val("glitch4_count", steps_seen - s0, 2);
    check_val("glitch4_dir", dir, 1'b0);

    // Illegal double edge, clear, then clear coincident with a set.
    s0 = steps_seen;
    set_ab(2'b11); wait_cyc(10);
    check_val("illegal_err", err, 1'b1);
    check_val("illegal_no_step", steps_seen - s0, 0);
    pulse_clr();
    check_val("err_cleared", err, 1'b0);
    set_ab(2'b00);                      // edge k next; decode at k+6
    repeat (6) @(posedge clk);
    @(negedge clk);
    err_clr = 1'b1;
    @(posedge clk);
    #2 check_val("err_set_wins", err, 1'b1);
    @(negedge clk);
    err_clr = 1'b0;
    wait_cyc(4);
    check_val("err_sticky", err, 1'b1);
    pulse_clr();
    check_val("err_cleared2", err, 1'b0);

    // Enable low through a full forward cycle.
    @(negedge clk);
    en = 1'b0;
    s0 = steps_seen;
    set_ab(2'b01); wait_cyc(10);
    set_ab(2'b11); wait_cyc(10);
    set_ab(2'b10); wait_cyc(10);
    set_ab(2'b00); wait_cyc(10);
    check_val("en_off_count", steps_seen - s0, 0);
    check_val("en_off_ab_q", ab_q, 2'b00);
    @(negedge clk);
    en = 1'b1;
    s0 = steps_seen;
    set_ab(2'b01); wait_cyc(10);
    check_val("en_on_count", steps_seen - s0, 1);
    check_val("en_on_dir", dir, 1'b1);
    set_ab(2'b00); wait_cyc(10);

    // Reset in the middle of filtering a 01 input.
    set_ab(2'b01); wait_cyc(3);
    s0 = steps_seen;
    rst = 1'b0;
    wait_cyc(2);
    check_val("midrst_ab_q", ab_q, 2'b00);
    rst = 1'b1;
    wait_cyc(12);
    check_val("midrst_count", steps_seen - s0, 1);
    check_val("midrst_dir", dir, 1'b1);
    check_val("midrst_err", err, 1'b0);
    set_ab(2'b00); wait_cyc(10);

    // Random walk: any next state, random holds (short ones are glitches),
    // occasional enable drops and error clears.
    for (int it = 0; it < 300; it++) begin
      rv   = 2'($urandom_range(0, 3));
      hold = $urandom_range(1, 12);
      @(negedge clk);
      a_in = rv[1];
      b_in = rv[0];
      en   = ($urandom_range(0, 7) != 0);
      for (int c = 0; c < hold; c++) begin
        err_clr = ($urandom_range(0, 15) == 0);
        @(negedge clk);
      end
      err_clr = 1'b0;
    end

    en = 1'b1;
    set_ab(2'b00);
    wait_cyc(20);
    check_val("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
